// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
// The FSM state names are referenced package-qualified where a module parameter shares the name.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BURST      = 4;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first set bit of valid at or after ptr, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     ptr,
    output logic               found,
    output logic [IDW-1:0]     idx
);

    logic [IDW-1:0] cand;

    // Scan from the farthest offset down so the closest valid producer wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDW'(k);
            if (valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ producers into one synchronous FIFO write port.
// Each FIFO word carries the source ID above the payload.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST      = DEF_BURST,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic                                fifo_full,
    output logic                                fifo_wr_en,
    output logic [IDW+DATA_WIDTH-1:0]           fifo_data_in,
    output logic                                grant_valid,
    output logic [IDW-1:0]                      grant_id
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    arb_state_e     state;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  beat_cnt;

    logic           in_burst;
    logic           accept_ok;
    logic           beat;
    logic           last_beat;
    logic           rel_now;
    logic [IDW-1:0] pick_ptr;
    logic           pick_found;
    logic [IDW-1:0] pick_idx;

    assign in_burst  = (state == fifo_arb_pkg::BURST);
    assign accept_ok = in_burst & ~fifo_full & ~rst;
    assign beat      = accept_ok & req_valid[owner];
    assign last_beat = beat & (beat_cnt == CW'(BURST - 1));
    assign rel_now   = last_beat | (in_burst & ~req_valid[owner] & ~fifo_full);

    // On release the next owner is searched from owner+1, which is the value rr_ptr is about to take.
    assign pick_ptr = in_burst ? (owner + IDW'(1)) : rr_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid (req_valid),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        req_ready = '0;
        if (accept_ok) begin
            req_ready[owner] = 1'b1;
        end
    end

    assign fifo_wr_en   = beat;
    assign fifo_data_in = beat ? {owner, req_data[owner]} : '0;
    assign grant_valid  = in_burst & ~rst;
    assign grant_id     = grant_valid ? owner : '0;

    // A full FIFO freezes everything: beat is low and rel_now cannot fire while fifo_full=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= fifo_arb_pkg::IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                fifo_arb_pkg::IDLE: begin
                    if (pick_found) begin
                        state    <= fifo_arb_pkg::BURST;
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                    end
                end
                fifo_arb_pkg::BURST: begin
                    if (rel_now) begin
                        rr_ptr   <= owner + IDW'(1);
                        beat_cnt <= '0;
                        if (pick_found) begin
                            owner <= pick_idx;
                        end else begin
                            state <= fifo_arb_pkg::IDLE;
                            owner <= '0;
                        end
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= fifo_arb_pkg::IDLE;
                    owner <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Table-driven bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, BURST=4).
// Each table row is one clock cycle of inputs plus the outputs expected mid-cycle.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int BURST      = 4;
    localparam int IDW        = 2;

    logic                               clk;
    logic                               rst;
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_ready;
    logic                               fifo_full;
    logic                               fifo_wr_en;
    logic [IDW+DATA_WIDTH-1:0]          fifo_data_in;
    logic                               grant_valid;
    logic [IDW-1:0]                     grant_id;

    typedef struct {
        string                     tag;
        logic                      rst;
        logic [NUM_REQ-1:0]        valid;
        logic                      full;
        logic [DATA_WIDTH-1:0]     data;
        logic                      exp_gv;
        logic [IDW-1:0]            exp_gid;
        logic [NUM_REQ-1:0]        exp_ready;
        logic                      exp_wr;
        logic [IDW+DATA_WIDTH-1:0] exp_din;
    } vec_t;

    vec_t vecs[$];
    int   check_cnt = 0;
    int   pass_cnt  = 0;

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .BURST      (BURST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void addv(input string tag, input logic r, input logic [3:0] v,
                                 input logic f, input logic [7:0] d, input logic gv,
                                 input logic [1:0] gid, input logic [3:0] rdy, input logic wr);
        vec_t t;
        t.tag       = tag;
        t.rst       = r;
        t.valid     = v;
        t.full      = f;
        t.data      = d;
        t.exp_gv    = gv;
        t.exp_gid   = gid;
        t.exp_ready = rdy;
        t.exp_wr    = wr;
        t.exp_din   = wr ? {gid, d} : '0;
        vecs.push_back(t);
    endfunction

    task automatic applyStimulus(input vec_t t);
        rst       = t.rst;
        req_valid = t.valid;
        fifo_full = t.full;
        req_data  = {NUM_REQ{t.data}};
    endtask

    task automatic checkOutput(input vec_t t, input int idx);
        logic [17:0] got;
        logic [17:0] exp;
        got = {grant_valid, grant_id, req_ready, fifo_wr_en, fifo_data_in};
        exp = {t.exp_gv, t.exp_gid, t.exp_ready, t.exp_wr, t.exp_din};
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("[TB] FAIL %s row %0d: got gv=%b gid=%0d rdy=%b wr=%b din=%h, expected gv=%b gid=%0d rdy=%b wr=%b din=%h",
                      t.tag, idx, grant_valid, grant_id, req_ready, fifo_wr_en, fifo_data_in,
                      t.exp_gv, t.exp_gid, t.exp_ready, t.exp_wr, t.exp_din);
        check_cnt++;
        if (!(fifo_wr_en && fifo_full) && $countones(req_ready) <= 1) pass_cnt++;
        else $display("[TB] FAIL %s row %0d safety: got wr=%b full=%b rdy=%b, expected no write when full and at most one ready",
                      t.tag, idx, fifo_wr_en, fifo_full, req_ready);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        req_data  = '0;

        // Producer 2 alone for six beats: bubble, 4 beats, seamless re-grant, 2 beats, release.
        addv("solo2", 1, 4'h0, 0, 8'h00, 0, 0, 4'h0, 0);
        addv("solo2", 0, 4'h4, 0, 8'h00, 0, 0, 4'h0, 0);
        for (int k = 0; k < 6; k++) addv("solo2", 0, 4'h4, 0, 8'h10 + 8'(k), 1, 2, 4'h4, 1);
        addv("solo2", 0, 4'h0, 0, 8'h00, 1, 2, 4'h4, 0);
        addv("solo2", 0, 4'h0, 0, 8'h00, 0, 0, 4'h0, 0);

        // All producers valid: 4-beat bursts in order 0,1,2,3 then back to 0.
        addv("allrr", 1, 4'h0, 0, 8'h00, 0, 0, 4'h0, 0);
        addv("allrr", 0, 4'hF, 0, 8'h00, 0, 0, 4'h0, 0);
        for (int n = 0; n < 17; n++)
            addv("allrr", 0, 4'hF, 0, 8'hA0 + 8'(n), 1, 2'((n / 4) % 4), 4'(1 << ((n / 4) % 4)), 1);

        // Stall on producer 1 after two beats, including a valid drop while full.
        addv("stall", 1, 4'h0, 0, 8'h00, 0, 0, 4'h0, 0);
        addv("stall", 0, 4'h2, 0, 8'h20, 0, 0, 4'h0, 0);
        addv("stall", 0, 4'h2, 0, 8'h21, 1, 1, 4'h2, 1);
        addv("stall", 0, 4'h2, 0, 8'h22, 1, 1, 4'h2, 1);
        addv("stall", 0, 4'h2, 1, 8'h23, 1, 1, 4'h0, 0);
        addv("stall", 0, 4'h0, 1, 8'h23, 1, 1, 4'h0, 0);
        addv("stall", 0, 4'h2, 1, 8'h23, 1, 1, 4'h0, 0);
        addv("stall", 0, 4'h2, 0, 8'h24, 1, 1, 4'h2, 1);
        addv("stall", 0, 4'h3, 0, 8'h25, 1, 1, 4'h2, 1);
        addv("stall", 0, 4'h3, 0, 8'h26, 1, 0, 4'h1, 1);
        addv("stall", 0, 4'h0, 0, 8'h00, 1, 0, 4'h1, 0);
        addv("stall", 0, 4'h0, 0, 8'h00, 0, 0, 4'h0, 0);

        // Early drop by 0 hands over to 3, then owner 3 drops and the pointer wraps to 0.
        addv("drop", 1, 4'h0, 0, 8'h00, 0, 0, 4'h0, 0);
        addv("drop", 0, 4'h9, 0, 8'h00, 0, 0, 4'h0, 0);
        addv("drop", 0, 4'h9, 0, 8'h40, 1, 0, 4'h1, 1);
        addv("drop", 0, 4'h9, 0, 8'h41, 1, 0, 4'h1, 1);
        addv("drop", 0, 4'h8, 0, 8'h42, 1, 0, 4'h1, 0);
        addv("drop", 0, 4'h8, 0, 8'h43, 1, 3, 4'h8, 1);
        addv("wrap", 0, 4'h5, 0, 8'h44, 1, 3, 4'h8, 0);
        addv("wrap", 0, 4'h5, 0, 8'h45, 1, 0, 4'h1, 1);
        addv("wrap", 0, 4'h0, 0, 8'h00, 1, 0, 4'h1, 0);
        addv("wrap", 0, 4'h0, 0, 8'h00, 0, 0, 4'h0, 0);

        // Reset in the middle of producer 2's burst, then restart from producer 0.
        addv("midrst", 1, 4'h0, 0, 8'h00, 0, 0, 4'h0, 0);
        addv("midrst", 0, 4'h4, 0, 8'h00, 0, 0, 4'h0, 0);
        addv("midrst", 0, 4'hF, 0, 8'h50, 1, 2, 4'h4, 1);
        addv("midrst", 0, 4'hF, 0, 8'h51, 1, 2, 4'h4, 1);
        addv("midrst", 1, 4'hF, 0, 8'h52, 0, 0, 4'h0, 0);
        addv("midrst", 0, 4'hF, 0, 8'h53, 0, 0, 4'h0, 0);
        addv("midrst", 0, 4'hF, 0, 8'h54, 1, 0, 4'h1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i], i);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
